ibex_test_data_mem_responder: RTL and testbench

Parametrised, synthesisable data-memory slave for the Ibex data bus (req/gnt/rvalid protocol). It sits on the core's LSU port in place of a behavioural memory. It adds the following features:
- Backing word array with byte-enable writes.
- Programmable grant delay.
- Programmable per-transaction response latency.
- Up to MaxOutstanding pipelined transactions.
- Error responses, both from address decode and from injection.

---
 rtl/ibex_test_mem_pkg.sv | 32 +++
 rtl/ibex_test_resp_fifo.sv | 60 ++++++
 rtl/ibex_test_data_mem_responder.sv | 127 ++++++++++++
 tb/tb_ibex_test_data_mem_responder.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ibex_test_mem_pkg.sv
// Shared types and helpers for the Ibex test data-memory responder.
package ibex_test_mem_pkg;

  // Field widths of the response entry in the default (32-bit data, 4-bit delay) configuration.
  localparam int RespDataWidth  = 32;
  localparam int RespDelayWidth = 4;

  // Response entry layout: read data, error flag, per-transaction response latency.
  typedef struct packed {
    logic [RespDataWidth-1:0]  rdata;
    logic                      err;
    logic [RespDelayWidth-1:0] delay;
  } resp_entry_t;

  // Number of byte lanes in a data word.
  function automatic int be_width(input int data_width);
    return data_width / 8;
  endfunction

  // Width of a word index into an array of the given depth (never zero).
  function automatic int word_idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // True when addr lies in [base, base + span); the subtraction avoids overflow at the top of the map.
  function automatic logic addr_in_range(input logic [63:0] addr,
                                         input logic [63:0] base,
                                         input logic [63:0] span);
    return (addr >= base) && ((addr - base) < span);
  endfunction

endpackage

// File: rtl/ibex_test_resp_fifo.sv
// In-order response FIFO with arbitrary (non power-of-two) depth.
// Exposes the head entry directly; the head latency countdown lives in the parent.
module ibex_test_resp_fifo #(
  parameter int  Depth = 4,
  parameter type entry_t = logic [7:0],
  localparam int CountWidth = $clog2(Depth + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  entry_t                push_data,
  input  logic                  pop,
  output entry_t                head,
  output logic                  full,
  output logic                  empty,
  output logic [CountWidth-1:0] count
);

  localparam int PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;

  entry_t                entries [Depth];
  logic [PtrWidth-1:0]   wr_ptr;
  logic [PtrWidth-1:0]   rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  // Pointers wrap at Depth rather than at a power of two.
  function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CountWidth'(Depth));
  assign empty   = (count == '0);
  assign head    = entries[rd_ptr];

  // Entry storage; contents are don't-care while not counted, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) entries[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping; push and pop together leave the count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ibex_test_data_mem_responder.sv
// Synthesisable data-memory slave for the Ibex LSU req/gnt/rvalid bus with
// programmable grant delay, per-transaction response latency, pipelined
// outstanding transactions and decode/injected error responses.
module ibex_test_data_mem_responder
  import ibex_test_mem_pkg::*;
#(
  parameter int                   AddrWidth      = 32,
  parameter int                   DataWidth      = 32,
  parameter int                   Depth          = 1024,
  parameter logic [AddrWidth-1:0] BaseAddr       = AddrWidth'(32'h0),
  parameter int                   MaxOutstanding = 4,
  parameter int                   DelayWidth     = 4,
  localparam int                  BeWidth        = be_width(DataWidth),
  localparam int                  OutWidth       = $clog2(MaxOutstanding + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DelayWidth-1:0] gnt_delay_i,
  input  logic [DelayWidth-1:0] rvalid_delay_i,
  input  logic                  err_inject_i,
  input  logic                  data_req_i,
  output logic                  data_gnt_o,
  output logic                  data_rvalid_o,
  input  logic                  data_we_i,
  input  logic [BeWidth-1:0]    data_be_i,
  input  logic [AddrWidth-1:0]  data_addr_i,
  input  logic [DataWidth-1:0]  data_wdata_i,
  output logic [DataWidth-1:0]  data_rdata_o,
  output logic                  data_err_o,
  output logic [OutWidth-1:0]   outstanding_o
);

  localparam int          IdxWidth  = word_idx_width(Depth);
  localparam int          ByteOffW  = $clog2(BeWidth);
  localparam logic [63:0] SpanBytes = 64'(Depth) * 64'(BeWidth);

  typedef struct packed {
    logic [DataWidth-1:0]  rdata;
    logic                  err;
    logic [DelayWidth-1:0] delay;
  } entry_t;

  logic [DataWidth-1:0]  mem [Depth];
  logic [DelayWidth-1:0] wait_cnt;
  logic [DelayWidth-1:0] elapsed;
  logic [AddrWidth-1:0]  offset;
  logic [IdxWidth-1:0]   word_idx;
  logic                  in_range;
  logic                  txn_err;
  logic                  accept;
  logic                  rvalid;
  logic                  full;
  logic                  empty;
  entry_t                push_entry;
  entry_t                head;

  // Address decode: low byte-offset bits are ignored when forming the word index.
  assign in_range = addr_in_range(64'(data_addr_i), 64'(BaseAddr), SpanBytes);
  assign offset   = data_addr_i - BaseAddr;
  assign word_idx = IdxWidth'(offset >> ByteOffW);
  assign txn_err  = !in_range || err_inject_i;

  // A full FIFO blocks the grant even if the head pops this cycle.
  assign data_gnt_o = !rst && data_req_i && (wait_cnt >= gnt_delay_i) && !full;
  assign accept     = data_req_i && data_gnt_o;

  // Count cycles of ungranted request; any gap in req or a grant restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (!data_req_i || data_gnt_o) begin
      wait_cnt <= '0;
    end else if (wait_cnt < gnt_delay_i) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Byte-masked array write at acceptance; errored transactions leave memory untouched.
  always_ff @(posedge clk) begin
    if (accept && data_we_i && !txn_err) begin
      for (int b = 0; b < BeWidth; b++) begin
        if (data_be_i[b]) mem[word_idx][b*8 +: 8] <= data_wdata_i[b*8 +: 8];
      end
    end
  end

  // Build the response entry; writes and errors return zero data, latency floors at one cycle.
  always_comb begin
    push_entry.rdata = '0;
    if (!data_we_i && !txn_err) push_entry.rdata = mem[word_idx];
    push_entry.err   = txn_err;
    push_entry.delay = (rvalid_delay_i == '0) ? DelayWidth'(1) : rvalid_delay_i;
  end

  ibex_test_resp_fifo #(
    .Depth   (MaxOutstanding),
    .entry_t (entry_t)
  ) u_resp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (accept),
    .push_data (push_entry),
    .pop       (rvalid),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (outstanding_o)
  );

  // Cycles the current head has spent as head; restarts whenever a new entry takes the head slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      elapsed <= '0;
    end else if (rvalid || empty) begin
      elapsed <= '0;
    end else begin
      elapsed <= elapsed + 1'b1;
    end
  end

  // The head responds once it has been head for delay cycles, then pops at the end of that cycle.
  assign rvalid        = !empty && (elapsed == head.delay - 1'b1);
  assign data_rvalid_o = rvalid;
  assign data_rdata_o  = rvalid ? head.rdata : '0;
  assign data_err_o    = rvalid && head.err;

endmodule

// File: tb/tb_ibex_test_data_mem_responder.sv
// Self-checking bench for ibex_test_data_mem_responder with a transaction-level reference model.
module tb_ibex_test_data_mem_responder;

  localparam int MaxOut = 4;
  localparam int Depth  = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  gnt_delay;
  logic [3:0]  rvalid_delay;
  logic        err_inject;
  logic        req;
  logic        gnt;
  logic        rvalid;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        err;
  logic [2:0]  outstanding;

  ibex_test_data_mem_responder #(
    .AddrWidth      (32),
    .DataWidth      (32),
    .Depth          (Depth),
    .BaseAddr       (32'h0),
    .MaxOutstanding (MaxOut),
    .DelayWidth     (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .gnt_delay_i    (gnt_delay),
    .rvalid_delay_i (rvalid_delay),
    .err_inject_i   (err_inject),
    .data_req_i     (req),
    .data_gnt_o     (gnt),
    .data_rvalid_o  (rvalid),
    .data_we_i      (we),
    .data_be_i      (be),
    .data_addr_i    (addr),
    .data_wdata_i   (wdata),
    .data_rdata_o   (rdata),
    .data_err_o     (err),
    .outstanding_o  (outstanding)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: expected responses with the cycle number in which each must appear.
  typedef struct {
    int          due;
    logic [31:0] rdata;
    logic        err;
  } exp_resp_t;

  exp_resp_t   q[$];
  logic [31:0] mem_model [int];
  int          edge_n   = 0;
  int          waited   = 0;
  int          last_due = 0;
  logic        e_gnt;
  logic        e_rvalid;
  logic        e_err;
  logic [31:0] e_rdata;
  int          e_out;

  task automatic drive(input logic r, input logic w, input logic [3:0] b,
                       input logic [31:0] a, input logic [31:0] d, input logic inj);
    req = r; we = w; be = b; addr = a; wdata = d; err_inject = inj;
  endtask

  // Expected outputs for the cycle ending at the next posedge.
  task automatic predict();
    int cur;
    cur      = edge_n + 1;
    e_out    = q.size();
    e_gnt    = !rst && req && (waited >= int'(gnt_delay)) && (q.size() < MaxOut);
    e_rvalid = (q.size() > 0) && (q[0].due == cur);
    e_rdata  = e_rvalid ? q[0].rdata : 32'h0;
    e_err    = e_rvalid && q[0].err;
  endtask

  // A transaction accepted at edge t heads the queue at max(t, predecessor's response cycle)
  // and responds d cycles later.
  task automatic model_accept();
    exp_resp_t   r;
    int          d;
    int          w;
    logic [31:0] v;
    d       = (rvalid_delay == 4'd0) ? 1 : int'(rvalid_delay);
    w       = int'(addr >> 2);
    r.err   = (addr >= 32'(Depth * 4)) || err_inject;
    r.rdata = 32'h0;
    if (!r.err) begin
      v = mem_model.exists(w) ? mem_model[w] : 32'h0;
      if (we) begin
        for (int b = 0; b < 4; b++) if (be[b]) v[8*b +: 8] = wdata[8*b +: 8];
        mem_model[w] = v;
      end else begin
        r.rdata = v;
      end
    end
    r.due    = ((last_due > edge_n) ? last_due : edge_n) + d;
    last_due = r.due;
    q.push_back(r);
  endtask

  task automatic model_clear();
    q.delete();
    waited   = 0;
    last_due = 0;
  endtask

  // Advance one clock edge, update the model from the predicted handshake, settle #1 after.
  task automatic advance();
    @(posedge clk);
    edge_n++;
    if (rst) begin
      model_clear();
    end else begin
      if (e_rvalid) void'(q.pop_front());
      if (e_gnt) model_accept();
      waited = (!req || e_gnt) ? 0 : waited + 1;
    end
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (gnt !== 1'b0)          begin errors++; $display("FAIL reset_gnt: got %b want 0", gnt); end
    checks++; if (rvalid !== 1'b0)       begin errors++; $display("FAIL reset_rvalid: got %b want 0", rvalid); end
    checks++; if (err !== 1'b0)          begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    checks++; if (rdata !== 32'h0)       begin errors++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    checks++; if (outstanding !== 3'd0)  begin errors++; $display("FAIL reset_outstanding: got %0d want 0", outstanding); end
    rst = 1'b0;
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    model_clear();
  endtask

  task automatic test_write_read();
    gnt_delay = 4'd0; rvalid_delay = 4'd1;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0:       drive(1'b1, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 1'b0);
        1:       drive(1'b1, 1'b0, 4'hF, 32'h10, 32'h0, 1'b0);
        default: drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
      endcase
      @(negedge clk); predict();
      checks++;
      if (gnt !== e_gnt || rvalid !== e_rvalid || err !== e_err || rdata !== e_rdata || outstanding !== 3'(e_out)) begin
        errors++;
        $display("FAIL write_read cyc %0d: got gnt=%b rv=%b err=%b rd=%h out=%0d, want gnt=%b rv=%b err=%b rd=%h out=%0d",
                 edge_n, gnt, rvalid, err, rdata, outstanding, e_gnt, e_rvalid, e_err, e_rdata, e_out);
      end
      if (i < 2) begin
        checks++; if (gnt !== 1'b1) begin errors++; $display("FAIL same_cycle_gnt %0d: got %b want 1", i, gnt); end
      end
      if (i == 2) begin
        checks++;
        if (rvalid !== 1'b1 || rdata !== 32'hDEADBEEF || err !== 1'b0) begin
          errors++; $display("FAIL read_back: got rv=%b rd=%h err=%b want rv=1 rd=deadbeef err=0", rvalid, rdata, err);
        end
      end
      advance();
    end
  endtask

  task automatic test_byte_enable();
    logic [31:0] last_rd;
    last_rd = 32'h0;
    gnt_delay = 4'd0; rvalid_delay = 4'd1;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0:       drive(1'b1, 1'b1, 4'hF,    32'h20, 32'h11223344, 1'b0);
        1:       drive(1'b1, 1'b1, 4'b0101, 32'h20, 32'hAABBCCDD, 1'b0);
        2:       drive(1'b1, 1'b0, 4'hF,    32'h20, 32'h0, 1'b0);
        default: drive(1'b0, 1'b0, 4'h0,    32'h0,  32'h0, 1'b0);
      endcase
      @(negedge clk); predict();
      checks++;
      if (gnt !== e_gnt || rvalid !== e_rvalid || err !== e_err || rdata !== e_rdata || outstanding !== 3'(e_out)) begin
        errors++;
        $display("FAIL byte_enable cyc %0d: got gnt=%b rv=%b err=%b rd=%h out=%0d, want gnt=%b rv=%b err=%b rd=%h out=%0d",
                 edge_n, gnt, rvalid, err, rdata, outstanding, e_gnt, e_rvalid, e_err, e_rdata, e_out);
      end
      if (rvalid === 1'b1) last_rd = rdata;
      advance();
    end
    checks++;
    if (last_rd !== 32'h11BB33DD) begin errors++; $display("FAIL be_merge: got %h want 11bb33dd", last_rd); end
  endtask

  task automatic test_gnt_delay();
    logic [13:0] gv;
    gv = '0;
    gnt_delay = 4'd3; rvalid_delay = 4'd1;
    for (int i = 0; i < 14; i++) begin
      if ((i <= 3) || (i == 5) || (i == 6) || (i >= 8 && i <= 11))
        drive(1'b1, 1'b0, 4'hF, 32'h20, 32'h0, 1'b0);
      else
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
      @(negedge clk); predict();
      checks++;
      if (gnt !== e_gnt || rvalid !== e_rvalid || err !== e_err || rdata !== e_rdata || outstanding !== 3'(e_out)) begin
        errors++;
        $display("FAIL gnt_delay cyc %0d: got gnt=%b rv=%b err=%b rd=%h out=%0d, want gnt=%b rv=%b err=%b rd=%h out=%0d",
                 edge_n, gnt, rvalid, err, rdata, outstanding, e_gnt, e_rvalid, e_err, e_rdata, e_out);
      end
      gv[i] = (gnt === 1'b1);
      advance();
    end
    checks++;
    if (gv !== 14'h0808) begin errors++; $display("FAIL gnt_pattern: got %b want %b", gv, 14'h0808); end
  endtask

  task automatic test_outstanding();
    int gnt_cyc[$];
    int rv_cyc[$];
    int grants;
    grants = 0;
    gnt_delay = 4'd0; rvalid_delay = 4'd5;
    for (int i = 0; i < 45; i++) begin
      drive(grants < 8, 1'b0, 4'hF, grants[0] ? 32'h20 : 32'h10, 32'h0, 1'b0);
      @(negedge clk); predict();
      checks++;
      if (gnt !== e_gnt || rvalid !== e_rvalid || err !== e_err || rdata !== e_rdata || outstanding !== 3'(e_out)) begin
        errors++;
        $display("FAIL outstanding cyc %0d: got gnt=%b rv=%b err=%b rd=%h out=%0d, want gnt=%b rv=%b err=%b rd=%h out=%0d",
                 edge_n, gnt, rvalid, err, rdata, outstanding, e_gnt, e_rvalid, e_err, e_rdata, e_out);
      end
      if (gnt === 1'b1) begin gnt_cyc.push_back(i); grants++; end
      if (rvalid === 1'b1) rv_cyc.push_back(i);
      advance();
    end
    checks++;
    if (gnt_cyc.size() < 5 || gnt_cyc[0] != 0 || gnt_cyc[3] != 3 || gnt_cyc[4] != 6) begin
      errors++; $display("FAIL grant_stall: got %0d grants, 4th/5th at %0d/%0d want 3/6", gnt_cyc.size(),
                         (gnt_cyc.size() > 3) ? gnt_cyc[3] : -1, (gnt_cyc.size() > 4) ? gnt_cyc[4] : -1);
    end
    checks++;
    if (rv_cyc.size() != 8 || rv_cyc[0] != 5) begin
      errors++; $display("FAIL resp_count: got %0d responses first at %0d want 8 first at 5", rv_cyc.size(),
                         (rv_cyc.size() > 0) ? rv_cyc[0] : -1);
    end else begin
      for (int k = 1; k < 8; k++) begin
        checks++;
        if (rv_cyc[k] - rv_cyc[k-1] != 5) begin
          errors++; $display("FAIL resp_spacing %0d: got %0d want 5", k, rv_cyc[k] - rv_cyc[k-1]);
        end
      end
    end
  endtask

  task automatic test_errors();
    gnt_delay = 4'd0; rvalid_delay = 4'd1;
    for (int i = 0; i < 6; i++) begin
      case (i)
        0:       drive(1'b1, 1'b1, 4'hF, 32'h0,    32'hCAFEF00D, 1'b0);
        1:       drive(1'b1, 1'b0, 4'hF, 32'h1000, 32'h0, 1'b0);
        2:       drive(1'b1, 1'b1, 4'hF, 32'h0,    32'h12345678, 1'b1);
        3:       drive(1'b1, 1'b0, 4'hF, 32'h0,    32'h0, 1'b0);
        default: drive(1'b0, 1'b0, 4'h0, 32'h0,    32'h0, 1'b0);
      endcase
      @(negedge clk); predict();
      checks++;
      if (gnt !== e_gnt || rvalid !== e_rvalid || err !== e_err || rdata !== e_rdata || outstanding !== 3'(e_out)) begin
        errors++;
        $display("FAIL errors cyc %0d: got gnt=%b rv=%b err=%b rd=%h out=%0d, want gnt=%b rv=%b err=%b rd=%h out=%0d",
                 edge_n, gnt, rvalid, err, rdata, outstanding, e_gnt, e_rvalid, e_err, e_rdata, e_out);
      end
      if (i == 2 || i == 3) begin
        checks++;
        if (rvalid !== 1'b1 || err !== 1'b1 || rdata !== 32'h0) begin
          errors++; $display("FAIL err_resp %0d: got rv=%b err=%b rd=%h want rv=1 err=1 rd=0", i, rvalid, err, rdata);
        end
      end
      if (i == 4) begin
        checks++;
        if (rvalid !== 1'b1 || err !== 1'b0 || rdata !== 32'hCAFEF00D) begin
          errors++; $display("FAIL err_no_write: got rv=%b err=%b rd=%h want rv=1 err=0 rd=cafef00d", rvalid, err, rdata);
        end
      end
      advance();
    end
  endtask

  task automatic test_reset_mid();
    int stray;
    stray = 0;
    gnt_delay = 4'd0; rvalid_delay = 4'd7;
    for (int i = 0; i < 4; i++) begin
      if (i < 3) drive(1'b1, 1'b0, 4'hF, 32'h10, 32'h0, 1'b0);
      else       drive(1'b0, 1'b0, 4'h0, 32'h0,  32'h0, 1'b0);
      @(negedge clk); predict();
      checks++;
      if (gnt !== e_gnt || rvalid !== e_rvalid || err !== e_err || rdata !== e_rdata || outstanding !== 3'(e_out)) begin
        errors++;
        $display("FAIL reset_mid cyc %0d: got gnt=%b rv=%b err=%b rd=%h out=%0d, want gnt=%b rv=%b err=%b rd=%h out=%0d",
                 edge_n, gnt, rvalid, err, rdata, outstanding, e_gnt, e_rvalid, e_err, e_rdata, e_out);
      end
      advance();
    end
    checks++;
    if (outstanding !== 3'd3) begin errors++; $display("FAIL pre_reset_outstanding: got %0d want 3", outstanding); end
    rst = 1'b1;
    drive(1'b1, 1'b0, 4'hF, 32'h10, 32'h0, 1'b0);
    #1;
    model_clear();
    checks++;
    if (rvalid !== 1'b0 || outstanding !== 3'd0 || gnt !== 1'b0) begin
      errors++; $display("FAIL async_reset: got rv=%b out=%0d gnt=%b want 0 0 0", rvalid, outstanding, gnt);
    end
    @(negedge clk); predict();
    advance();
    rst = 1'b0;
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); predict();
      checks++;
      if (gnt !== e_gnt || rvalid !== e_rvalid || err !== e_err || rdata !== e_rdata || outstanding !== 3'(e_out)) begin
        errors++;
        $display("FAIL post_reset cyc %0d: got gnt=%b rv=%b err=%b rd=%h out=%0d, want gnt=%b rv=%b err=%b rd=%h out=%0d",
                 edge_n, gnt, rvalid, err, rdata, outstanding, e_gnt, e_rvalid, e_err, e_rdata, e_out);
      end
      if (rvalid !== 1'b0) stray++;
      advance();
    end
    checks++;
    if (stray != 0) begin errors++; $display("FAIL stray_rvalid: got %0d want 0", stray); end
  endtask

  task automatic test_random();
    logic        r;
    logic [31:0] a;
    gnt_delay = 4'd0; rvalid_delay = 4'd1;
    for (int i = 0; i < 476; i++) begin
      if (i < 16) begin
        drive(1'b1, 1'b1, 4'hF, 32'h40 + 32'(i * 4), $urandom, 1'b0);
      end else if (i < 416) begin
        r = ($urandom_range(3) != 0);
        if (i % 50 == 0) begin
          r = 1'b0;
          gnt_delay = 4'($urandom_range(3));
        end
        rvalid_delay = 4'($urandom_range(6));
        if ($urandom_range(15) == 0) a = 32'h2000 + 32'($urandom_range(255));
        else                         a = 32'h40 + 32'($urandom_range(15) * 4) + 32'($urandom_range(3));
        drive(r, 1'($urandom_range(1)), 4'($urandom_range(15)), a, $urandom, $urandom_range(7) == 0);
      end else begin
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
      end
      @(negedge clk); predict();
      checks++;
      if (gnt !== e_gnt || rvalid !== e_rvalid || err !== e_err || rdata !== e_rdata || outstanding !== 3'(e_out)) begin
        errors++;
        $display("FAIL random cyc %0d: got gnt=%b rv=%b err=%b rd=%h out=%0d, want gnt=%b rv=%b err=%b rd=%h out=%0d",
                 edge_n, gnt, rvalid, err, rdata, outstanding, e_gnt, e_rvalid, e_err, e_rdata, e_out);
      end
      advance();
    end
    checks++;
    if (outstanding !== 3'd0) begin errors++; $display("FAIL random_drain: got %0d want 0", outstanding); end
  endtask

  initial begin
    rst = 1'b1;
    gnt_delay = 4'd0;
    rvalid_delay = 4'd1;
    drive(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    test_reset();
    test_write_read();
    test_byte_enable();
    test_gnt_delay();
    test_outstanding();
    test_errors();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
